// File: rtl/key_pkg.sv
// Shared types for the key event tracker: event kinds and scanner FSM states.
package key_pkg;

  typedef enum logic [1:0] {
    PRESS   = 2'd0,
    RELEASE = 2'd1,
    REPEAT  = 2'd2
  } evt_kind_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN_REL,
    SCAN_PRS,
    COMMIT
  } scan_state_t;

endpackage

// File: rtl/key_event_tracker_if.sv
// Event stream handshake between the tracker (master) and its consumer (slave).
interface key_evt_if #(
  parameter int KW = 8
);
  import key_pkg::*;

  logic            evt_valid;
  logic            evt_ready;
  logic [KW-1:0]   evt_code;
  evt_kind_t       evt_kind;

  modport master (output evt_valid, evt_code, evt_kind, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_kind, output evt_ready);
endinterface

// File: rtl/key_event_tracker_fifo.sv
// Generic event FIFO; push visible at head next cycle; push when full is refused unless a pop coincides.
// Head output holds the last popped value while empty.
module evt_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  output logic         full,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DEPTH-1:0] FULL_CNT = DEPTH[DEPTH-1:0];

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [DEPTH-1:0] count;
  logic [W-1:0]     last_q;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_dat = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + DEPTH'(1);
      else if (do_pop && !do_push) count <= count - DEPTH'(1);
      // Shadow the head so the outputs freeze on the last value once drained
      if (!empty) last_q <= mem[rd_ptr];
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/key_event_tracker.sv
// Tracks N_KEYS keycodes, emits PRESS/RELEASE/REPEAT events into a FIFO; scan takes 2*N_KEYS+2 cycles.
// Events refused by a full FIFO are dropped and flagged on the sticky overflow output.
module key_event_tracker
  import key_pkg::*;
#(
  parameter int KW           = 8,
  parameter int N_KEYS       = 4,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 5,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 tick,
  input  logic                 hold,
  input  logic [N_KEYS*KW-1:0] keycodes,
  input  logic                 ovf_clr,
  output logic                 overflow,
  output logic                 busy,
  key_evt_if.master            evt
);
  localparam int IW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = $clog2(CMAX + 1);

  typedef logic [N_KEYS-1:0][KW-1:0] slots_t;

  slots_t       in_q, prev, snap;
  scan_state_t  state_q, state_d;
  logic [IW-1:0] idx;
  logic         last_slot, scan_start, rel_hit, prs_hit;
  logic         push, full, empty, pop, drop;
  logic [KW-1:0] push_code;
  evt_kind_t    push_kind;
  logic [KW+1:0] head_dat;
  logic         rep_act, rep_pend;
  logic [KW-1:0] rep_code;
  logic [CW-1:0] rep_cnt;

  assign last_slot  = (idx == IW'(N_KEYS - 1));
  assign scan_start = (state_q == IDLE) && (in_q != prev);

  // Slot i qualifies if nonzero, absent from the other report, and first of its value in its own report
  always_comb begin
    rel_hit = (prev[idx] != '0);
    prs_hit = (snap[idx] != '0);
    for (int j = 0; j < N_KEYS; j++) begin
      if (snap[j] == prev[idx]) rel_hit = 1'b0;
      if (prev[j] == snap[idx]) prs_hit = 1'b0;
      if (j < int'(idx)) begin
        if (prev[j] == prev[idx]) rel_hit = 1'b0;
        if (snap[j] == snap[idx]) prs_hit = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (scan_start) state_d = SCAN_REL;
      SCAN_REL: if (last_slot)  state_d = SCAN_PRS;
      SCAN_PRS: if (last_slot)  state_d = COMMIT;
      COMMIT:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_code = rep_code;
    push_kind = REPEAT;
    busy      = (state_q != IDLE) || scan_start;
    case (state_q)
      SCAN_REL: if (rel_hit) begin
        push = 1'b1; push_code = prev[idx]; push_kind = RELEASE;
      end
      SCAN_PRS: if (prs_hit) begin
        push = 1'b1; push_code = snap[idx]; push_kind = PRESS;
      end
      IDLE:     push = rep_pend && hold && !scan_start;
      default:  push = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_q <= '0;
      prev <= '0;
      snap <= '0;
      idx  <= '0;
    end else begin
      in_q <= keycodes;
      case (state_q)
        IDLE: if (scan_start) begin
          snap <= in_q;
          idx  <= '0;
        end
        SCAN_REL, SCAN_PRS: idx <= last_slot ? '0 : idx + IW'(1);
        COMMIT: prev <= snap;
        default: ;
      endcase
    end
  end

  // A new PRESS re-arms the channel and discards any expiry still pending for the old key
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rep_act  <= 1'b0;
      rep_pend <= 1'b0;
      rep_code <= '0;
      rep_cnt  <= '0;
    end else if (push && push_kind == PRESS) begin
      rep_act  <= 1'b1;
      rep_pend <= 1'b0;
      rep_code <= push_code;
      rep_cnt  <= CW'(REPEAT_DELAY);
    end else if (push && push_kind == RELEASE && rep_act && push_code == rep_code) begin
      rep_act  <= 1'b0;
      rep_pend <= 1'b0;
    end else if (rep_act) begin
      if (!hold) begin
        rep_pend <= 1'b0;
      end else begin
        if (push) rep_pend <= 1'b0;
        if (tick) begin
          if (rep_cnt <= CW'(1)) begin
            rep_pend <= 1'b1;
            rep_cnt  <= CW'(REPEAT_RATE);
          end else begin
            rep_cnt <= rep_cnt - CW'(1);
          end
        end
      end
    end
  end

  assign pop  = evt.evt_valid && evt.evt_ready;
  assign drop = push && full && !pop;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)     overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  evt_fifo #(.W(KW + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .push     (push),
    .push_dat ({push_code, push_kind}),
    .full     (full),
    .pop      (pop),
    .empty    (empty),
    .head_dat (head_dat)
  );

  assign evt.evt_valid = !empty;
  assign evt.evt_code  = head_dat[KW+1:2];
  assign evt.evt_kind  = evt_kind_t'(head_dat[1:0]);
endmodule

// File: tb/tb_key_event_tracker.sv
// Directed bench for key_event_tracker: scan timing, repeat, dedup, overflow and mid-scan reset.
module tb_key_event_tracker;
  import key_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n, tick, hold, ovf_clr;
  logic [31:0] keycodes;
  logic        overflow, busy;

  key_evt_if #(.KW(8)) evt ();

  key_event_tracker #(
    .KW(8), .N_KEYS(4), .REPEAT_DELAY(3), .REPEAT_RATE(2), .FIFO_DEPTH(4)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .tick     (tick),
    .hold     (hold),
    .keycodes (keycodes),
    .ovf_clr  (ovf_clr),
    .overflow (overflow),
    .busy     (busy),
    .evt      (evt)
  );

  always #5 Clk = ~Clk;

  int         checks = 0;
  int         errors = 0;
  int         rd = 0;
  int         busy_cnt = 0;
  logic [9:0] ev_log [$];

  always @(negedge Clk) begin
    if (busy) busy_cnt++;
    if (evt.evt_valid && evt.evt_ready) ev_log.push_back({evt.evt_code, evt.evt_kind});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic exp_evt(input string tag, input logic [7:0] code, input logic [1:0] kind);
    if (ev_log.size() > rd) begin
      chk({tag, "_code"}, {24'd0, ev_log[rd][9:2]}, {24'd0, code});
      chk({tag, "_kind"}, {30'd0, ev_log[rd][1:0]}, {30'd0, kind});
      rd++;
    end else begin
      chk({tag, "_count"}, ev_log.size(), rd + 1);
    end
  endtask

  task automatic exp_none(input string tag);
    chk(tag, ev_log.size(), rd);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(3);
  endtask

  initial begin
    int n;
    int b0;
    Reset_n = 1'b0; tick = 1'b0; hold = 1'b0; ovf_clr = 1'b0;
    keycodes = '0;  evt.evt_ready = 1'b1;
    cyc(3);
    chk("rst_valid", evt.evt_valid, 0);
    chk("rst_code", evt.evt_code, 0);
    chk("rst_kind", evt.evt_kind, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    Reset_n = 1'b1;
    cyc(2);

    // 1: single press, latency and busy span
    b0 = busy_cnt;
    keycodes = 32'h0000_0004;
    n = 0;
    while (!evt.evt_valid && n < 40) begin
      cyc(1);
      n++;
    end
    chk("s1_latency", n, 7);
    chk("s1_head_code", evt.evt_code, 8'h04);
    chk("s1_head_kind", evt.evt_kind, PRESS);
    cyc(10);
    chk("s1_busy_len", busy_cnt - b0, 10);
    exp_evt("s1_press", 8'h04, PRESS);
    exp_none("s1_only");

    // 2: auto-repeat after 3rd tick, then every 2nd
    hold = 1'b1;
    pulse_tick();
    pulse_tick();
    exp_none("s2_tick2");
    pulse_tick();
    exp_evt("s2_rep1", 8'h04, REPEAT);
    pulse_tick();
    exp_none("s2_tick4");
    pulse_tick();
    exp_evt("s2_rep2", 8'h04, REPEAT);
    keycodes = '0;
    cyc(14);
    exp_evt("s2_rel", 8'h04, RELEASE);
    repeat (4) pulse_tick();
    exp_none("s2_no_rep");
    hold = 1'b0;

    // 3: reorder gives nothing; replace one key
    keycodes = 32'h0000_0504;
    cyc(14);
    exp_evt("s3_p04", 8'h04, PRESS);
    exp_evt("s3_p05", 8'h05, PRESS);
    b0 = busy_cnt;
    keycodes = 32'h0000_0405;
    cyc(14);
    exp_none("s3_reorder");
    chk("s3_reorder_busy", busy_cnt - b0, 10);
    keycodes = 32'h0000_1605;
    cyc(14);
    exp_evt("s3_r04", 8'h04, RELEASE);
    exp_evt("s3_p16", 8'h16, PRESS);

    // 4: duplicates in one report collapse
    keycodes = '0;
    cyc(14);
    exp_evt("s4_r05", 8'h05, RELEASE);
    exp_evt("s4_r16", 8'h16, RELEASE);
    keycodes = 32'h0000_0707;
    cyc(14);
    exp_evt("s4_p07", 8'h07, PRESS);
    exp_none("s4_p07_single");
    keycodes = '0;
    cyc(14);
    exp_evt("s4_r07", 8'h07, RELEASE);
    exp_none("s4_r07_single");

    // 5: stalled consumer fills the FIFO, then overflow
    evt.evt_ready = 1'b0;
    keycodes = 32'h0000_0001; cyc(14);
    keycodes = 32'h0000_0201; cyc(14);
    keycodes = 32'h0003_0201; cyc(14);
    keycodes = 32'h0403_0201; cyc(14);
    chk("s5_ovf_full", overflow, 0);
    chk("s5_valid", evt.evt_valid, 1);
    chk("s5_head_code", evt.evt_code, 8'h01);
    keycodes = 32'h0403_0205; cyc(14);
    chk("s5_ovf_set", overflow, 1);
    keycodes = 32'h0403_0605; cyc(14);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("s5_ovf_clr", overflow, 0);
    evt.evt_ready = 1'b1;
    cyc(8);
    exp_evt("s5_d1", 8'h01, PRESS);
    exp_evt("s5_d2", 8'h02, PRESS);
    exp_evt("s5_d3", 8'h03, PRESS);
    exp_evt("s5_d4", 8'h04, PRESS);
    exp_none("s5_drained");
    chk("s5_empty", evt.evt_valid, 0);
    chk("s5_hold_code", evt.evt_code, 8'h04);

    // 6: reset in the middle of SCAN_PRS
    evt.evt_ready = 1'b0;
    keycodes = 32'h0000_0B0A;
    cyc(8);
    chk("s6_pre_busy", busy, 1);
    chk("s6_pre_valid", evt.evt_valid, 1);
    chk("s6_pre_ovf", overflow, 1);
    Reset_n = 1'b0;
    #1;
    chk("s6_rst_valid", evt.evt_valid, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_ovf", overflow, 0);
    chk("s6_rst_code", evt.evt_code, 0);
    cyc(2);
    evt.evt_ready = 1'b1;
    Reset_n = 1'b1;
    cyc(16);
    exp_evt("s6_p0a", 8'h0A, PRESS);
    exp_evt("s6_p0b", 8'h0B, PRESS);
    exp_none("s6_only");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
